// File: rtl/core_uart_lite_if.sv
// AXI4-Lite bus bundle between the core's IN/OUT master and core_uart_lite.
// Signal names follow the AXI channel names; the slave modport is the UART side.
interface core_uart_lite_if;
    logic [3:0]  ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [3:0]  AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    modport master (
        output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
    );

    modport slave (
        input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
        output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
    );
endinterface

// File: rtl/core_uart_lite.sv
// AXI4-Lite UART: RX/TX byte FIFOs plus 8N1 serializer/deserializer.
// Map: 0x0 RXFIFO (R), 0x4 TXFIFO (W), 0x8 STAT (R), 0xC CTRL (W).
// Optional build macro UART_LOOPBACK_EN: RX deserializer listens to the
// internal TX line instead of UART_RX.
// Reset RST_N is synchronous, active-low.

// Byte FIFO with wrap-bit pointers; clear beats any same-cycle push/pop.
module core_uart_lite_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       clr,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       push_ok
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wp, rp;
    logic [7:0]  mem [DEPTH];
    logic        pop_ok;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when it coincides with a pop.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rp[AW-1:0]];

    // Pointer update; clear and reset both empty the FIFO.
    always_ff @(posedge CLK) begin
        if (!RST_N || clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_ok) wp <= wp + (AW+1)'(1);
            if (pop_ok)  rp <= rp + (AW+1)'(1);
        end
    end

    // Storage, no reset needed: contents are only visible through the pointers.
    always_ff @(posedge CLK) begin
        if (push_ok && RST_N && !clr) mem[wp[AW-1:0]] <= din;
    end
endmodule

module core_uart_lite #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    core_uart_lite_if.slave  bus,
    input  logic             UART_RX,
    output logic             UART_TX
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

    typedef struct packed {
        logic [24:0] rsvd_hi;
        logic        frame_err;
        logic        overrun;
        logic        rsvd4;
        logic        tx_full;
        logic        tx_empty;
        logic        rx_full;
        logic        rx_valid;
    } stat_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- FIFOs ----------------
    logic       rx_clr, rx_push, rx_pop, rx_empty, rx_full, rx_push_ok;
    logic       tx_clr, tx_push, tx_pop, tx_empty, tx_full, tx_push_ok;
    logic [7:0] rx_dout, tx_dout, rx_sh, tx_sh;
    logic [7:0] wdata_q;

    core_uart_lite_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .CLK(CLK), .RST_N(RST_N), .clr(rx_clr), .push(rx_push), .pop(rx_pop),
        .din(rx_sh), .dout(rx_dout), .empty(rx_empty), .full(rx_full), .push_ok(rx_push_ok)
    );

    core_uart_lite_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .CLK(CLK), .RST_N(RST_N), .clr(tx_clr), .push(tx_push), .pop(tx_pop),
        .din(wdata_q), .dout(tx_dout), .empty(tx_empty), .full(tx_full), .push_ok(tx_push_ok)
    );

    // ---------------- read channel ----------------
    logic        arready_q, rvalid_q, ar_hs, stat_rd;
    logic [31:0] rdata_q, rd_mux;
    logic        overrun_q, ferr_q;
    stat_t       stat;

    assign ar_hs   = arready_q && bus.ARVALID;
    assign stat_rd = ar_hs && (bus.ARADDR[3:2] == 2'd2);
    assign rx_pop  = ar_hs && (bus.ARADDR[3:2] == 2'd0) && !rx_empty;

    // Read data selection, sampled into RDATA at the AR handshake.
    always_comb begin
        stat           = '0;
        stat.rx_valid  = !rx_empty;
        stat.rx_full   = rx_full;
        stat.tx_empty  = tx_empty;
        stat.tx_full   = tx_full;
        stat.overrun   = overrun_q;
        stat.frame_err = ferr_q;
        rd_mux         = '0;
        case (bus.ARADDR[3:2])
            2'd0:    rd_mux = rx_empty ? 32'h0 : {24'h0, rx_dout};
            2'd2:    rd_mux = stat;
            default: rd_mux = '0;
        endcase
    end

    // One outstanding read: ARREADY only while no R beat is pending.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_mux;
        end else if (rvalid_q) begin
            if (bus.RREADY) begin
                rvalid_q  <= 1'b0;
                arready_q <= 1'b1;
            end
        end else begin
            arready_q <= 1'b1;
        end
    end

    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = 2'b00;

    // ---------------- write channel ----------------
    logic       awready_q, wready_q, bvalid_q, aw_got, w_got, wstrb_q, wr_en, ctrl_wr;
    logic [1:0] waddr_q;

    assign wr_en   = aw_got && w_got && !bvalid_q;
    assign tx_push = wr_en && (waddr_q == 2'd1) && wstrb_q;
    assign ctrl_wr = wr_en && (waddr_q == 2'd3) && wstrb_q;
    assign tx_clr  = ctrl_wr && wdata_q[0];
    assign rx_clr  = ctrl_wr && wdata_q[1];

    // AW and W are latched independently; the register write fires the cycle
    // after both are held, and B completion reopens both channels.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= 1'b0;
        end else if (bvalid_q) begin
            if (bus.BREADY) begin
                bvalid_q  <= 1'b0;
                aw_got    <= 1'b0;
                w_got     <= 1'b0;
                awready_q <= 1'b1;
                wready_q  <= 1'b1;
            end
        end else if (wr_en) begin
            bvalid_q <= 1'b1;
        end else begin
            if (awready_q && bus.AWVALID) begin
                aw_got    <= 1'b1;
                awready_q <= 1'b0;
                waddr_q   <= bus.AWADDR[3:2];
            end else if (!aw_got) begin
                awready_q <= 1'b1;
            end
            if (wready_q && bus.WVALID) begin
                w_got    <= 1'b1;
                wready_q <= 1'b0;
                wdata_q  <= bus.WDATA[7:0];
                wstrb_q  <= bus.WSTRB[0];
            end else if (!w_got) begin
                wready_q <= 1'b1;
            end
        end
    end

    assign bus.AWREADY = awready_q;
    assign bus.WREADY  = wready_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = 2'b00;

    // ---------------- TX serializer ----------------
    uart_st_e      tx_st;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic          tx_q, tx_go;

    // Load the next byte from IDLE, or straight out of the last STOP cycle so
    // consecutive bytes leave without an idle gap.
    assign tx_go  = !tx_empty && !tx_clr &&
                    ((tx_st == S_IDLE) || ((tx_st == S_STOP) && (tx_cnt == BIT_END)));
    assign tx_pop = tx_go;

    // 8N1 transmit FSM; each state lasts one bit time.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tx_st  <= S_IDLE;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh  <= '0;
            tx_q   <= 1'b1;
        end else begin
            case (tx_st)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_go) begin
                        tx_sh  <= tx_dout;
                        tx_q   <= 1'b0;
                        tx_cnt <= '0;
                        tx_st  <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        tx_bit <= '0;
                        tx_q   <= tx_sh[0];
                        tx_st  <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_q  <= 1'b1;
                            tx_st <= S_STOP;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx_sh  <= {1'b0, tx_sh[7:1]};
                            tx_q   <= tx_sh[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (tx_cnt == BIT_END) begin
                        tx_cnt <= '0;
                        if (tx_go) begin
                            tx_sh <= tx_dout;
                            tx_q  <= 1'b0;
                            tx_st <= S_START;
                        end else begin
                            tx_st <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: tx_st <= S_IDLE;
            endcase
        end
    end

    assign UART_TX = tx_q;

    // ---------------- RX deserializer ----------------
    logic          rx_in, rx_s, rx_bad;
    logic [1:0]    rx_sync;
    uart_st_e      rx_st;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;

`ifdef UART_LOOPBACK_EN
    assign rx_in = tx_q;
`else
    assign rx_in = UART_RX;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge CLK) begin
        if (!RST_N) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], rx_in};
    end
    assign rx_s = rx_sync[1];

    assign rx_push = (rx_st == S_STOP) && (rx_cnt == BIT_END) && rx_s;
    assign rx_bad  = (rx_st == S_STOP) && (rx_cnt == BIT_END) && !rx_s;

    // 8N1 receive FSM: half-bit start check, then mid-bit samples.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rx_st  <= S_IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
        end else begin
            case (rx_st)
                S_IDLE: begin
                    if (!rx_s) begin
                        rx_cnt <= '0;
                        rx_st  <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_st  <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s, rx_sh[7:1]};
                        if (rx_bit == 3'd7) rx_st  <= S_STOP;
                        else                rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt <= '0;
                        rx_st  <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_st <= S_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new event wins over a same-cycle STAT read clear.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            overrun_q <= (rx_push && !rx_push_ok && !rx_clr) || (overrun_q && !stat_rd);
            ferr_q    <= rx_bad || (ferr_q && !stat_rd);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.ARADDR[1:0], bus.AWADDR[1:0], bus.WDATA[31:8], bus.WSTRB[3:1]};
endmodule
